mc_sequencer: RTL and testbench

- Multicycle main-control FSM for the MIPS-subset core; sequences one shared ALU, one unified instruction/data memory and the register file across several cycles per instruction.
- Replaces the single-cycle path decode. Drives datapath muxes and enables, and emits alu_op to the existing ALU-control decoder.
- Adds a memory handshake (mem_req/mem_ready) so the memory may take a variable number of cycles.

---
 rtl/mc_sequencer.sv | 164 ++++++++++++++++
 tb/tb_mc_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mc_sequencer.sv
// Multicycle main-control sequencer: one state per datapath step, with a
// mem_req/mem_ready handshake so memory accesses can take any number of cycles.
module mc_sequencer #(
   parameter int OP_W = 6,
   parameter int ST_W = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [OP_W-1:0] op,
   input  logic            zero,
   input  logic            mem_ready,
   output logic            mem_req,
   output logic            iord,
   output logic            mem_write,
   output logic            ir_write,
   output logic            reg_dst,
   output logic            mem_to_reg,
   output logic            reg_write,
   output logic            alu_src_a,
   output logic [1:0]      alu_src_b,
   output logic [1:0]      alu_op,
   output logic [1:0]      pc_src,
   output logic            pc_en,
   output logic            illegal_op,
   output logic [ST_W-1:0] state_dbg
);

   typedef enum logic [ST_W-1:0] {
      S_FETCH  = ST_W'(0),
      S_DECODE = ST_W'(1),
      S_MEMADR = ST_W'(2),
      S_MEMRD  = ST_W'(3),
      S_MEMWB  = ST_W'(4),
      S_MEMWR  = ST_W'(5),
      S_EXEC   = ST_W'(6),
      S_ALUWB  = ST_W'(7),
      S_BRANCH = ST_W'(8),
      S_ADDIEX = ST_W'(9),
      S_ADDIWB = ST_W'(10),
      S_JUMP   = ST_W'(11)
   } state_t;

   localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
   localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
   localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
   localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
   localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
   localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

   state_t r_state;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= S_FETCH;
      end else begin
         case (r_state)
            S_FETCH:  if (mem_ready) r_state <= S_DECODE;
            S_DECODE: begin
               case (op)
                  OP_LW, OP_SW: r_state <= S_MEMADR;
                  OP_R:         r_state <= S_EXEC;
                  OP_BEQ:       r_state <= S_BRANCH;
                  OP_ADDI:      r_state <= S_ADDIEX;
                  OP_J:         r_state <= S_JUMP;
                  default:      r_state <= S_FETCH;
               endcase
            end
            S_MEMADR: begin
               if (op == OP_LW)      r_state <= S_MEMRD;
               else if (op == OP_SW) r_state <= S_MEMWR;
               else                  r_state <= S_FETCH;
            end
            S_MEMRD:  if (mem_ready) r_state <= S_MEMWB;
            S_MEMWR:  if (mem_ready) r_state <= S_FETCH;
            S_EXEC:   r_state <= S_ALUWB;
            S_ADDIEX: r_state <= S_ADDIWB;
            // Unused encodings fall through here and recover to FETCH.
            default:  r_state <= S_FETCH;
         endcase
      end
   end

   logic w_op_known;
   logic w_mem_req, w_mem_write, w_ir_write, w_reg_write, w_pc_en, w_illegal;

   assign w_op_known = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                       (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);

   always_comb begin
      w_mem_req   = 1'b0;
      w_mem_write = 1'b0;
      w_ir_write  = 1'b0;
      w_reg_write = 1'b0;
      w_pc_en     = 1'b0;
      w_illegal   = 1'b0;
      iord        = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      alu_op      = 2'b00;
      pc_src      = 2'b00;
      case (r_state)
         S_FETCH: begin
            w_mem_req  = 1'b1;
            alu_src_b  = 2'b01;
            w_ir_write = mem_ready;
            w_pc_en    = mem_ready;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            w_illegal = !w_op_known;
         end
         S_MEMADR, S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            w_mem_req = 1'b1;
            iord      = 1'b1;
         end
         S_MEMWB: begin
            mem_to_reg  = 1'b1;
            w_reg_write = 1'b1;
         end
         S_MEMWR: begin
            w_mem_req   = 1'b1;
            w_mem_write = 1'b1;
            iord        = 1'b1;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         S_ALUWB: begin
            reg_dst     = 1'b1;
            w_reg_write = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_src    = 2'b01;
            w_pc_en   = zero;
         end
         S_ADDIWB: w_reg_write = 1'b1;
         S_JUMP: begin
            pc_src  = 2'b10;
            w_pc_en = 1'b1;
         end
         default: ;
      endcase
   end

   // Side-effecting strobes are held off while reset is asserted so an
   // abandoned instruction can never complete a write.
   assign mem_req    = w_mem_req   & reset_n;
   assign mem_write  = w_mem_write & reset_n;
   assign ir_write   = w_ir_write  & reset_n;
   assign reg_write  = w_reg_write & reset_n;
   assign pc_en      = w_pc_en     & reset_n;
   assign illegal_op = w_illegal   & reset_n;
   assign state_dbg  = r_state;

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized scoreboard bench for mc_sequencer: the driver pushes the expected
// per-cycle control word from an instruction-level model; a monitor compares.
module tb_mc_sequencer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] op;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg;
   logic       reg_write, alu_src_a, pc_en, illegal_op;
   logic [1:0] alu_src_b, alu_op, pc_src;
   logic [3:0] state_dbg;

   mc_sequencer #(.OP_W(6), .ST_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_src(pc_src), .pc_en(pc_en), .illegal_op(illegal_op), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic       mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
      logic [1:0] alu_src_b, alu_op, pc_src;
      logic       pc_en, illegal_op;
   } exp_t;

   localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5, K_ILL = 6;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_cyc = 0;

   function automatic int classify(input logic [5:0] o);
      case (o)
         6'b100011: return K_LW;
         6'b101011: return K_SW;
         6'b000000: return K_R;
         6'b000100: return K_BEQ;
         6'b001000: return K_ADDI;
         6'b000010: return K_J;
         default:   return K_ILL;
      endcase
   endfunction

   // Control word required in a given state, straight from the state table.
   function automatic exp_t exp_of(input int st, input bit rdy, input bit z,
                                   input logic [5:0] o, input bit rn);
      exp_t e;
      e = '0;
      e.st = 4'(st);
      case (st)
         0:  begin e.mem_req = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_en = rdy; end
         1:  begin e.alu_src_b = 2'b11; e.illegal_op = (classify(o) == K_ILL); end
         2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
         3:  begin e.mem_req = 1; e.iord = 1; end
         4:  begin e.mem_to_reg = 1; e.reg_write = 1; end
         5:  begin e.mem_req = 1; e.mem_write = 1; e.iord = 1; end
         6:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
         7:  begin e.reg_dst = 1; e.reg_write = 1; end
         8:  begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_en = z; end
         9:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
         10: begin e.reg_write = 1; end
         11: begin e.pc_src = 2'b10; e.pc_en = 1; end
         default: ;
      endcase
      if (!rn) begin
         e.mem_req = 0; e.mem_write = 0; e.ir_write = 0;
         e.reg_write = 0; e.pc_en = 0; e.illegal_op = 0;
      end
      return e;
   endfunction

   // Drive one cycle of inputs and record the response expected this cycle.
   task automatic step(input int st, input bit rdy, input logic [5:0] o,
                       input bit z, input bit rn);
      reset_n   = rn;
      op        = o;
      zero      = z;
      mem_ready = rdy;
      q.push_back(exp_of(st, rdy, z, o, rn));
      @(posedge clk);
      #1;
   endtask

   function automatic bit rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Memory access state: mw wait cycles, then the single ready cycle.
   task automatic mem_access(input int st, input int mw, input logic [5:0] o);
      for (int i = 0; i < mw; i++) step(st, 1'b0, o, rbit(), 1'b1);
      step(st, 1'b1, o, rbit(), 1'b1);
   endtask

   task automatic do_instr(input logic [5:0] o, input int fw, input int mw, input bit zb);
      for (int i = 0; i < fw; i++) step(0, 1'b0, o, rbit(), 1'b1);
      step(0, 1'b1, o, rbit(), 1'b1);
      step(1, rbit(), o, rbit(), 1'b1);
      case (classify(o))
         K_LW: begin
            step(2, rbit(), o, rbit(), 1'b1);
            mem_access(3, mw, o);
            step(4, rbit(), o, rbit(), 1'b1);
         end
         K_SW: begin
            step(2, rbit(), o, rbit(), 1'b1);
            mem_access(5, mw, o);
         end
         K_R: begin
            step(6, rbit(), o, rbit(), 1'b1);
            step(7, rbit(), o, rbit(), 1'b1);
         end
         K_BEQ:  step(8, rbit(), o, zb, 1'b1);
         K_ADDI: begin
            step(9, rbit(), o, rbit(), 1'b1);
            step(10, rbit(), o, rbit(), 1'b1);
         end
         K_J:    step(11, rbit(), o, rbit(), 1'b1);
         default: ;
      endcase
   endtask

   // Monitor: every cycle is an output event; compare mid-cycle.
   exp_t got;
   assign got = {state_dbg, mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg,
                 reg_write, alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op};

   always @(negedge clk) begin
      n_cyc++;
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         n_cmp++;
         if (got !== e) begin
            n_bad++;
            $display("FAIL ctrl_word cyc=%0d got st=%0d word=%h required st=%0d word=%h",
                     n_cyc, got.st, got, e.st, e);
         end
      end
   end

   initial begin
      logic [5:0] o;
      logic [5:0] ops [6];
      ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
      reset_n = 1'b0; op = 6'b0; zero = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      // Reset state, then reset abandoning a stalled store.
      step(0, 1'b1, 6'b101011, 1'b0, 1'b0);
      step(0, 1'b1, 6'b101011, 1'b0, 1'b1);
      step(1, 1'b0, 6'b101011, 1'b0, 1'b1);
      step(2, 1'b0, 6'b101011, 1'b0, 1'b1);
      step(5, 1'b0, 6'b101011, 1'b0, 1'b1);
      step(5, 1'b0, 6'b101011, 1'b0, 1'b0);
      step(0, 1'b1, 6'b101011, 1'b0, 1'b0);
      // Directed instructions.
      do_instr(6'b100011, 0, 0, 1'b0);
      do_instr(6'b101011, 0, 3, 1'b0);
      do_instr(6'b000100, 0, 0, 1'b1);
      do_instr(6'b000100, 0, 0, 1'b0);
      do_instr(6'b000000, 0, 0, 1'b0);
      do_instr(6'b001000, 0, 0, 1'b0);
      do_instr(6'b000010, 0, 0, 1'b0);
      do_instr(6'b111111, 0, 0, 1'b0);
      do_instr(6'b100011, 5, 2, 1'b0);
      // Random instruction stream with random fetch and data waits.
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            do begin
               o = 6'($urandom);
            end while (classify(o) != K_ILL);
         end else begin
            o = ops[$urandom_range(0, 5)];
         end
         do_instr(o, $urandom_range(0, 3), $urandom_range(0, 3), rbit());
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL queue_drain got %0d pending required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
